// File: rtl/atm_bank_responder.sv
// Account-server responder for the ATM transaction interface.
// One request at a time: PIN check, then deposit/withdraw/query, then response.
module atm_bank_responder #(
   parameter int               NUM_ACCTS = 4,
   parameter int               BAL_W     = 33,
   parameter int               AMT_W     = 11,
   parameter logic [3:0]       PIN_VAL   = 4'b0101,
   parameter logic [BAL_W-1:0] INIT_BAL  = BAL_W'(1000),
   parameter int               MAX_TRIES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [1:0]       req_acct,
   input  logic [3:0]       req_pin,
   input  logic [AMT_W-1:0] req_amount,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [2:0]       rsp_status,
   output logic [BAL_W-1:0] rsp_balance
);

   localparam int FW = $clog2(MAX_TRIES + 1);
   localparam int SW = BAL_W + 1;

   localparam logic [1:0] OP_DEP = 2'd1;
   localparam logic [1:0] OP_WDR = 2'd2;

   localparam logic [2:0] ST_OK       = 3'd0;
   localparam logic [2:0] ST_BAD_PIN  = 3'd1;
   localparam logic [2:0] ST_LOCKED   = 3'd2;
   localparam logic [2:0] ST_INSUFF   = 3'd3;
   localparam logic [2:0] ST_OVERFLOW = 3'd4;
   localparam logic [2:0] ST_BAD_ACCT = 3'd5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      EXEC  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [1:0]       op_q;
   logic [1:0]       acct_q;
   logic [3:0]       pin_q;
   logic [AMT_W-1:0] amt_q;
   logic             err_q;
   logic [2:0]       err_st_q;

   logic [BAL_W-1:0] bal      [NUM_ACCTS];
   logic [FW-1:0]    fail_cnt [NUM_ACCTS];
   logic             lock     [NUM_ACCTS];

   logic             acct_ok;
   logic [FW-1:0]    fail_nxt;
   logic [BAL_W-1:0] cur;
   logic [SW-1:0]    sum;
   logic [2:0]       exec_st;
   logic [BAL_W-1:0] exec_bal;
   logic [BAL_W-1:0] exec_new;
   logic             exec_commit;

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (req_valid) state_nxt = CHECK;
         CHECK:   state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign acct_ok  = int'(acct_q) < NUM_ACCTS;
   assign fail_nxt = fail_cnt[acct_q] + FW'(1);
   assign cur      = bal[acct_q];
   assign sum      = {1'b0, cur} + SW'(amt_q);

   // Error paths still pass through EXEC so every response has the same latency.
   always_comb begin
      exec_st     = ST_OK;
      exec_bal    = cur;
      exec_new    = cur;
      exec_commit = 1'b0;
      if (err_q) begin
         exec_st  = err_st_q;
         exec_bal = '0;
      end else begin
         unique case (op_q)
            OP_DEP: begin
               if (sum[BAL_W]) begin
                  exec_st = ST_OVERFLOW;
               end else begin
                  exec_new    = sum[BAL_W-1:0];
                  exec_bal    = sum[BAL_W-1:0];
                  exec_commit = 1'b1;
               end
            end
            OP_WDR: begin
               if (BAL_W'(amt_q) > cur) begin
                  exec_st = ST_INSUFF;
               end else begin
                  exec_new    = cur - BAL_W'(amt_q);
                  exec_bal    = cur - BAL_W'(amt_q);
                  exec_commit = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q        <= '0;
         acct_q      <= '0;
         pin_q       <= '0;
         amt_q       <= '0;
         err_q       <= 1'b0;
         err_st_q    <= '0;
         rsp_status  <= '0;
         rsp_balance <= '0;
         for (int i = 0; i < NUM_ACCTS; i++) begin
            bal[i]      <= INIT_BAL;
            fail_cnt[i] <= '0;
            lock[i]     <= 1'b0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  acct_q <= req_acct;
                  pin_q  <= req_pin;
                  amt_q  <= req_amount;
               end
            end
            CHECK: begin
               err_q <= 1'b1;
               if (!acct_ok) begin
                  err_st_q <= ST_BAD_ACCT;
               end else if (lock[acct_q]) begin
                  err_st_q <= ST_LOCKED;
               end else if (pin_q != PIN_VAL) begin
                  // The locking request itself still reports BAD_PIN.
                  err_st_q         <= ST_BAD_PIN;
                  fail_cnt[acct_q] <= fail_nxt;
                  if (fail_nxt == FW'(MAX_TRIES)) lock[acct_q] <= 1'b1;
               end else begin
                  err_q            <= 1'b0;
                  fail_cnt[acct_q] <= '0;
               end
            end
            EXEC: begin
               rsp_status  <= exec_st;
               rsp_balance <= exec_bal;
               if (exec_commit) bal[acct_q] <= exec_new;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_atm_bank_responder.sv
// Self-checking bench for atm_bank_responder: directed scenarios plus
// randomized traffic against a spec-level account model.
module tb_atm_bank_responder;

   localparam int NUM_ACCTS = 4;
   localparam longint MAX_BAL = (longint'(1) << 33) - 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [1:0]  req_acct = '0;
   logic [3:0]  req_pin = '0;
   logic [10:0] req_amount = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [2:0]  rsp_status;
   logic [32:0] rsp_balance;

   int n_cmp = 0;
   int n_err = 0;

   longint mbal  [NUM_ACCTS];
   int     mfail [NUM_ACCTS];
   bit     mlock [NUM_ACCTS];

   atm_bank_responder dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_acct(req_acct),
      .req_pin(req_pin), .req_amount(req_amount),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_status(rsp_status), .rsp_balance(rsp_balance)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NUM_ACCTS; i++) begin
         mbal[i] = 1000; mfail[i] = 0; mlock[i] = 0;
      end
   endtask

   task automatic model_txn(input int op, input int acct, input int pin,
                            input longint amt,
                            output logic [2:0] st, output logic [32:0] b);
      longint r;
      r = 0;
      if (acct >= NUM_ACCTS) st = 5;
      else if (mlock[acct]) st = 2;
      else if (pin != 5) begin
         st = 1;
         mfail[acct]++;
         if (mfail[acct] == 3) mlock[acct] = 1;
      end else begin
         mfail[acct] = 0;
         st = 0;
         r = mbal[acct];
         if (op == 1) begin
            if (mbal[acct] + amt > MAX_BAL) st = 4;
            else begin mbal[acct] += amt; r = mbal[acct]; end
         end else if (op == 2) begin
            if (amt > mbal[acct]) st = 3;
            else begin mbal[acct] -= amt; r = mbal[acct]; end
         end
      end
      b = 33'(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic run_txn(input int op, input int acct, input int pin,
                          input int amt,
                          output logic [2:0] st, output logic [32:0] b,
                          output int lat, output bit post_ok);
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 2'(op); req_acct = 2'(acct);
      req_pin = 4'(pin); req_amount = 11'(amt);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      st = rsp_status;
      b = rsp_balance;
      @(posedge clk);
      @(negedge clk);
      post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      n_cmp++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 ||
          rsp_status !== 3'd0 || rsp_balance !== 33'd0) begin
         n_err++;
         $display("FAIL reset: rdy=%b vld=%b st=%0d bal=%0d want 1/0/0/0",
                  req_ready, rsp_valid, rsp_status, rsp_balance);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_verify();
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      model_txn(0, 0, 5, 0, est, eb);
      run_txn(0, 0, 5, 0, st, b, lat, post);
      n_cmp++;
      if (lat != 2) begin
         n_err++; $display("FAIL verify_latency: got %0d want 2", lat);
      end
      n_cmp++;
      if (st !== est || b !== eb || eb !== 33'd1000) begin
         n_err++; $display("FAIL verify: got %0d/%0d want %0d/%0d", st, b, est, eb);
      end
      n_cmp++;
      if (!post) begin
         n_err++; $display("FAIL verify_handshake: got vld=%b rdy=%b want 0/1",
                           rsp_valid, req_ready);
      end
   endtask

   task automatic test_deposit_withdraw();
      int ops[3]   = '{1, 2, 3};
      int accts[3] = '{1, 1, 0};
      int amts[3]  = '{100, 100, 0};
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      for (int i = 0; i < 3; i++) begin
         model_txn(ops[i], accts[i], 5, amts[i], est, eb);
         run_txn(ops[i], accts[i], 5, amts[i], st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb) begin
            n_err++;
            $display("FAIL dep_wdr[%0d]: got %0d/%0d want %0d/%0d", i, st, b, est, eb);
         end
      end
   endtask

   task automatic test_withdraw_edges();
      int amts[4] = '{1001, 1000, 0, 1};
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      for (int i = 0; i < 4; i++) begin
         model_txn(2, 2, 5, amts[i], est, eb);
         run_txn(2, 2, 5, amts[i], st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb) begin
            n_err++;
            $display("FAIL wdr_edge[%0d]: got %0d/%0d want %0d/%0d", i, st, b, est, eb);
         end
      end
   endtask

   task automatic test_lockout();
      int pins[5] = '{3, 3, 3, 5, 5};
      int ops[5]  = '{0, 0, 0, 0, 1};
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      for (int i = 0; i < 5; i++) begin
         model_txn(ops[i], 3, pins[i], 20, est, eb);
         run_txn(ops[i], 3, pins[i], 20, st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb) begin
            n_err++;
            $display("FAIL lockout[%0d]: got %0d/%0d want %0d/%0d", i, st, b, est, eb);
         end
      end
      do_reset();
      model_txn(3, 3, 5, 0, est, eb);
      run_txn(3, 3, 5, 0, st, b, lat, post);
      n_cmp++;
      if (st !== est || b !== eb) begin
         n_err++;
         $display("FAIL unlock_by_reset: got %0d/%0d want %0d/%0d", st, b, est, eb);
      end
   endtask

   task automatic test_fail_clear();
      int pins[6] = '{9, 0, 5, 15, 4, 5};
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      for (int i = 0; i < 6; i++) begin
         model_txn(0, 0, pins[i], 0, est, eb);
         run_txn(0, 0, pins[i], 0, st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb) begin
            n_err++;
            $display("FAIL fail_clear[%0d]: got %0d/%0d want %0d/%0d", i, st, b, est, eb);
         end
      end
   endtask

   task automatic test_stall_and_abort();
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      model_txn(1, 1, 5, 250, est, eb);
      rsp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_acct = 2'd1;
      req_pin = 4'd5; req_amount = 11'd250;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      for (int c = 0; c < 5; c++) begin
         // A competing request during the stall must be ignored.
         req_valid = (c == 2);
         req_op = 2'd2; req_acct = 2'd1; req_amount = 11'd7;
         @(posedge clk); @(negedge clk);
         n_cmp++;
         if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
             rsp_status !== est || rsp_balance !== eb) begin
            n_err++;
            $display("FAIL stall[%0d]: vld=%b rdy=%b %0d/%0d want 1/0 %0d/%0d",
                     c, rsp_valid, req_ready, rsp_status, rsp_balance, est, eb);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_err++; $display("FAIL stall_release: vld=%b rdy=%b want 0/1", rsp_valid, req_ready);
      end
      model_txn(3, 1, 5, 0, est, eb);
      run_txn(3, 1, 5, 0, st, b, lat, post);
      n_cmp++;
      if (st !== est || b !== eb) begin
         n_err++; $display("FAIL stall_ignore: got %0d/%0d want %0d/%0d", st, b, est, eb);
      end
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'd1; req_acct = 2'd1;
      req_pin = 4'd5; req_amount = 11'd500;
      @(posedge clk); @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_status !== 3'd0) begin
         n_err++;
         $display("FAIL abort: vld=%b rdy=%b st=%0d want 0/1/0", rsp_valid, req_ready, rsp_status);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      for (int a = 0; a < NUM_ACCTS; a++) begin
         model_txn(3, a, 5, 0, est, eb);
         run_txn(3, a, 5, 0, st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb) begin
            n_err++;
            $display("FAIL abort_bal[%0d]: got %0d/%0d want %0d/%0d", a, st, b, est, eb);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] st, est; logic [32:0] b, eb; int lat; bit post;
      int op, acct, pin, amt;
      for (int i = 0; i < 60; i++) begin
         op   = int'($urandom_range(0, 3));
         acct = int'($urandom_range(0, 3));
         pin  = ($urandom_range(0, 9) < 7) ? 5 : int'($urandom_range(0, 15));
         amt  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 2047));
         model_txn(op, acct, pin, amt, est, eb);
         run_txn(op, acct, pin, amt, st, b, lat, post);
         n_cmp++;
         if (st !== est || b !== eb || lat != 2 || !post) begin
            n_err++;
            $display("FAIL random[%0d] op=%0d acct=%0d pin=%0d amt=%0d: got %0d/%0d lat=%0d post=%0b want %0d/%0d lat=2 post=1",
                     i, op, acct, pin, amt, st, b, lat, post, est, eb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_verify();
      test_deposit_withdraw();
      test_withdraw_edges();
      test_lockout();
      test_fail_clear();
      test_stall_and_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
